prog_loader: RTL
================

Name: prog_loader

Overview:
Hardware program loader for the CPU core family, parametrised in address and instruction width. It accepts an instruction stream over a valid/ready handshake and writes it into instruction memory at a base address. It holds the CPU in reset during loading, muxes the memory address between loader and CPU PC, and then releases the CPU for a bounded or unbounded run. It replaces bench-level programming tasks, so a single controller can load and run successive programs.

Parameters:
ADDR_WIDTH, 4, instruction memory address width; DEPTH = 2**ADDR_WIDTH
INSTR_WIDTH, 8, instruction word width
RUN_WIDTH, 16, width of run-cycle budget
SETTLE_CYCLES, 2, cycles between end of load and CPU reset release (>=1)

Ports:
clk  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-high
load_start  in  1  start a load session (sampled each cycle)
abort  in  1  return to IDLE immediately
load_base  in  ADDR_WIDTH  first write address (latched on accepted load_start)
load_count  in  ADDR_WIDTH+1  words to load (latched); 0 = rerun existing program
run_cycles  in  RUN_WIDTH  CPU run budget (latched); 0 = run until load_start/abort
in_valid  in  1  instruction word valid
in_data  in  INSTR_WIDTH  instruction word
in_ready  out  1  loader accepts word this cycle
cpu_pc  in  ADDR_WIDTH  CPU fetch address
mem_addr  out  ADDR_WIDTH  instruction memory address
mem_we  out  1  instruction memory write enable
mem_wdata  out  INSTR_WIDTH  instruction memory write data
cpu_reset  out  1  CPU reset, active-high
prog_enable  out  1  1 = loader owns memory address
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on budgeted run completion
error  out  1  sticky protocol error flag

Behaviour:
- Reset: state=IDLE, wr_addr=0, words_left=0, run_cnt=0, cpu_reset=1, prog_enable=1, in_ready=0, mem_we=0, busy=0, done=0, error=0.
- States: IDLE, LOAD, SETTLE, RUN. Outputs decode from registered state: cpu_reset = (state!=RUN); prog_enable = (state==IDLE||LOAD); in_ready = (state==LOAD).
- mem_addr = prog_enable ? wr_addr : cpu_pc. mem_we = in_valid&&in_ready. mem_wdata = in_data. Write takes effect at the handshake edge, with zero added latency.
- IDLE: when load_start=1, latch base, count, and budget. Set wr_addr=load_base. If count=0 go to SETTLE, otherwise go to LOAD.
- Count > DEPTH: clamp words_left to DEPTH and set error.
- LOAD: each handshake writes mem[wr_addr] and increments wr_addr modulo DEPTH (wraps 15->0 at default). Decrement words_left. On the handshake where words_left is 1, go to SETTLE. If in_valid=0, hold state and write nothing.
- SETTLE: hold for exactly SETTLE_CYCLES cycles (cpu_reset=1, prog_enable=0), then go to RUN with run_cnt=0.
- RUN: cpu_reset=0 and run_cnt increments each cycle.
  - Budget nonzero: on the cycle where run_cnt == budget-1, go to IDLE. The CPU sees exactly `budget` unreset cycles. done=1 for the first IDLE cycle.
  - Budget 0: stay in RUN indefinitely; done is never pulsed.
- load_start in RUN: go directly to LOAD with the new latched parameters; cpu_reset=1 from the next cycle. done is not pulsed.
- load_start in LOAD or SETTLE: ignored; set error.
- abort in any state: go to IDLE at the next edge with no done pulse. abort beats a simultaneous load_start. A handshake coincident with abort still writes.
- error clears only on reset.
- Asynchronous reset mid-LOAD or mid-RUN: outputs take their reset values immediately; already-written memory words are retained.

Test Plan:
- Default params: load_base=0, load_count=12, run_cycles=300, 12 back-to-back words -> mem_we high 12 cycles at addr 0..11; cpu_reset falls 2 cycles after last write, stays low exactly 300 cycles; done pulses once.
- load_base=14, load_count=4, words A0..A3 -> writes at addr 14,15,0,1 (wrap); error stays 0.
- Stream with in_valid gaps (valid 1,0,0,1,1), load_count=3 -> exactly 3 writes, addresses contiguous; state remains LOAD during gaps.
- load_count=0, run_cycles=5 -> no mem_we; SETTLE 2 cycles, cpu_reset low 5 cycles, done pulse; mem_addr follows cpu_pc only while prog_enable=0.
- run_cycles=0, then load_start mid-RUN with load_count=2 -> cpu_reset rises next cycle, 2 writes, no done pulse; a second load_start during LOAD sets error=1 and is ignored.
- load_count=20 -> 16 writes, error=1; then abort asserted simultaneously with load_start during RUN -> IDLE next cycle, cpu_reset=1, no done pulse.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - instruction memory program loader with CPU reset and run-budget control
module prog_loader #(
   parameter int ADDR_WIDTH    = 4,
   parameter int INSTR_WIDTH   = 8,
   parameter int RUN_WIDTH     = 16,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_start,
   input  logic                   abort,
   input  logic [ADDR_WIDTH-1:0]  load_base,
   input  logic [ADDR_WIDTH:0]    load_count,
   input  logic [RUN_WIDTH-1:0]   run_cycles,
   input  logic                   in_valid,
   input  logic [INSTR_WIDTH-1:0] in_data,
   output logic                   in_ready,
   input  logic [ADDR_WIDTH-1:0]  cpu_pc,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic                   mem_we,
   output logic [INSTR_WIDTH-1:0] mem_wdata,
   output logic                   cpu_reset,
   output logic                   prog_enable,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   localparam int SETW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SETW-1:0]       SETTLE_LAST = SETW'(SETTLE_CYCLES - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_W     = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   ONE_WORD    = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [RUN_WIDTH-1:0]  ONE_RUN     = {{(RUN_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
   logic [ADDR_WIDTH:0]    words_left_q, words_left_d;
   logic [RUN_WIDTH-1:0]   run_cnt_q, run_cnt_d;
   logic [RUN_WIDTH-1:0]   budget_q, budget_d;
   logic [SETW-1:0]        settle_cnt_q, settle_cnt_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;
   logic                   launch;
   logic                   handshake;

   assign cpu_reset   = (state_q != S_RUN);
   assign prog_enable = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign in_ready    = (state_q == S_LOAD);
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign error       = error_q;
   assign handshake   = in_valid && in_ready;
   assign mem_we      = handshake;
   assign mem_wdata   = in_data;
   assign mem_addr    = prog_enable ? wr_addr_q : cpu_pc;

   always_comb begin
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      words_left_d = words_left_q;
      run_cnt_d    = run_cnt_q;
      budget_d     = budget_q;
      settle_cnt_d = settle_cnt_q;
      done_d       = 1'b0;
      error_d      = error_q;
      launch       = 1'b0;

      case (state_q)
         S_IDLE: begin
            launch = load_start;
         end
         S_LOAD: begin
            if (load_start) error_d = 1'b1;
            if (handshake) begin
               wr_addr_d    = wr_addr_q + 1'b1;
               words_left_d = words_left_q - ONE_WORD;
               if (words_left_q == ONE_WORD) begin
                  state_d      = S_SETTLE;
                  settle_cnt_d = '0;
               end
            end
         end
         S_SETTLE: begin
            if (load_start) error_d = 1'b1;
            if (settle_cnt_q == SETTLE_LAST) begin
               state_d   = S_RUN;
               run_cnt_d = '0;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            run_cnt_d = run_cnt_q + ONE_RUN;
            if (load_start) begin
               launch = 1'b1;
            end else if ((budget_q != '0) && (run_cnt_q == budget_q - ONE_RUN)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over a coincident load_start, so no parameters are latched
      if (launch && !abort) begin
         wr_addr_d    = load_base;
         budget_d     = run_cycles;
         settle_cnt_d = '0;
         if (load_count > DEPTH_W) begin
            words_left_d = DEPTH_W;
            error_d      = 1'b1;
         end else begin
            words_left_d = load_count;
         end
         state_d = (load_count == '0) ? S_SETTLE : S_LOAD;
      end

      if (abort) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wr_addr_q    <= '0;
         words_left_q <= '0;
         run_cnt_q    <= '0;
         budget_q     <= '0;
         settle_cnt_q <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         words_left_q <= words_left_d;
         run_cnt_q    <= run_cnt_d;
         budget_q     <= budget_d;
         settle_cnt_q <= settle_cnt_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

endmodule
